// File: rtl/mips_pkg.sv
// mips_pkg: shared state, opcode constants and defaults for the MIPS fetch stage
package mips_pkg;
    typedef enum logic {RUN, HALT} state_t;
    localparam logic [5:0] OP_J = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] FN_SYSCALL = 6'h0c;
    localparam logic [31:0] HALT_CODE_DEFAULT = 32'd10;
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC priority mux (jr > j/jal > taken branch > sequential)
module pc_next_sel
    import mips_pkg::*;
(
    input  logic        beq,
    input  logic        bne,
    input  logic        j,
    input  logic        jal,
    input  logic        jr,
    input  logic        equal,
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic [15:0] instr_imm,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        jump_taken,
    output logic        br_taken
);
    assign jump_taken = jr || j || jal;
    assign br_taken = !jump_taken && ((beq && equal) || (bne && !equal));
    assign next_pc = jr ? (rs_data & 32'hFFFF_FFFC) :
                     (j || jal) ? {pc_plus4[31:28], instr_index, 2'b00} :
                     br_taken ? pc_plus4 + branch_offset(instr_imm) :
                     pc_plus4;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, RUN/HALT machine and debug counters of the fetch stage
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int IMEM_AW = 10,
    parameter logic [31:0] HALT_CODE = HALT_CODE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [31:0]        instr,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        instr_out,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               beq,
    input  logic               bne,
    input  logic               j,
    input  logic               jal,
    input  logic               jr,
    input  logic               syscall,
    input  logic               equal,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        v0,
    output logic               run,
    output logic               halted,
    output logic [31:0]        instr_cnt,
    output logic [15:0]        jump_cnt,
    output logic [15:0]        br_taken_cnt
);
    state_t state;
    logic [31:0] next_pc;
    logic jump_taken, br_taken, halt_req;
    assign pc_plus4 = pc + 32'd4;
    assign imem_addr = pc[IMEM_AW+1:2];
    assign instr_out = instr;
    assign halt_req = syscall && v0 == HALT_CODE;
    pc_next_sel u_sel (
        .beq(beq),
        .bne(bne),
        .j(j),
        .jal(jal),
        .jr(jr),
        .equal(equal),
        .pc_plus4(pc_plus4),
        .instr_index(instr[25:0]),
        .instr_imm(instr[15:0]),
        .rs_data(rs_data),
        .next_pc(next_pc),
        .jump_taken(jump_taken),
        .br_taken(br_taken)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc <= RESET_PC;
            run <= 1'b1;
            halted <= 1'b0;
            instr_cnt <= '0;
            jump_cnt <= '0;
            br_taken_cnt <= '0;
        end else if (state == RUN) begin
            instr_cnt <= instr_cnt + 32'd1;
            jump_cnt <= jump_cnt + {15'd0, jump_taken && !halt_req};
            br_taken_cnt <= br_taken_cnt + {15'd0, br_taken && !halt_req};
            pc <= halt_req ? pc : next_pc;
            state <= halt_req ? HALT : RUN;
            run <= !halt_req;
            halted <= halt_req;
        end else if (go) begin
            pc <= pc_plus4;
            state <= RUN;
            run <= 1'b1;
            halted <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a rule-level model
module tb_fetch_unit;
    import mips_pkg::*;
    logic clk = 1'b0;
    logic rst, go, beq, bne, j, jal, jr, syscall, equal;
    logic [31:0] instr, rs_data, v0;
    logic [9:0] imem_addr;
    logic [31:0] instr_out, pc, pc_plus4, instr_cnt;
    logic run, halted;
    logic [15:0] jump_cnt, br_taken_cnt;
    logic [31:0] m_pc, m_ic;
    logic [15:0] m_jc, m_bc;
    logic m_halt;
    int vectors = 0;
    int miscompares = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .go(go), .instr(instr), .imem_addr(imem_addr),
        .instr_out(instr_out), .pc(pc), .pc_plus4(pc_plus4), .beq(beq), .bne(bne),
        .j(j), .jal(jal), .jr(jr), .syscall(syscall), .equal(equal), .rs_data(rs_data),
        .v0(v0), .run(run), .halted(halted), .instr_cnt(instr_cnt), .jump_cnt(jump_cnt),
        .br_taken_cnt(br_taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("imem_addr", {22'd0, imem_addr}, {22'd0, m_pc[11:2]});
        chk("instr_out", instr_out, instr);
        chk("run", {31'd0, run}, {31'd0, !m_halt});
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        chk("instr_cnt", instr_cnt, m_ic);
        chk("jump_cnt", {16'd0, jump_cnt}, {16'd0, m_jc});
        chk("br_taken_cnt", {16'd0, br_taken_cnt}, {16'd0, m_bc});
    endtask

    task automatic tick(input bit do_chk);
        logic [31:0] np4;
        logic signed [31:0] off;
        np4 = m_pc + 32'd4;
        off = $signed(instr[15:0]);
        off = off * 4;
        if (rst) begin
            m_pc = 32'd0; m_halt = 1'b0; m_ic = '0; m_jc = '0; m_bc = '0;
        end else if (m_halt) begin
            if (go) begin m_pc = np4; m_halt = 1'b0; end
        end else begin
            m_ic = m_ic + 32'd1;
            if (syscall && v0 == 32'd10) m_halt = 1'b1;
            else if (jr) begin m_pc = rs_data & ~32'd3; m_jc = m_jc + 16'd1; end
            else if (j || jal) begin
                m_pc = (np4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 4);
                m_jc = m_jc + 16'd1;
            end else if ((beq && equal) || (bne && !equal)) begin
                m_pc = np4 + off;
                m_bc = m_bc + 16'd1;
            end else m_pc = np4;
        end
        @(posedge clk);
        #1;
        if (do_chk) check_all();
    endtask

    task automatic idle();
        go = 0; beq = 0; bne = 0; j = 0; jal = 0; jr = 0; syscall = 0; equal = 0;
        instr = 32'd0; rs_data = 32'd0; v0 = 32'd0;
    endtask

    task automatic rand_in();
        instr = $urandom;
        beq = $urandom_range(0, 5) == 0;
        bne = $urandom_range(0, 5) == 0;
        j = $urandom_range(0, 7) == 0;
        jal = $urandom_range(0, 7) == 0;
        jr = $urandom_range(0, 7) == 0;
        syscall = $urandom_range(0, 6) == 0;
        equal = $urandom_range(0, 1) == 1;
        rs_data = $urandom;
        v0 = $urandom_range(0, 2) == 0 ? 32'd10 : $urandom;
        go = $urandom_range(0, 2) == 0;
    endtask

    initial begin
        m_pc = '0; m_ic = '0; m_jc = '0; m_bc = '0; m_halt = 1'b0;
        idle();
        rst = 1;
        go = 1;
        tick(0);
        tick(1);
        rst = 0;
        go = 0;
        repeat (4) tick(1);
        instr = {OP_BEQ, 10'd0, 16'hFFFF};
        beq = 1; equal = 1;
        tick(1);
        equal = 0;
        tick(1);
        idle();
        jr = 1; rs_data = 32'h0040_0020;
        tick(1);
        idle();
        jal = 1; instr = {OP_JAL, 26'h0100008};
        tick(1);
        idle();
        jr = 1; rs_data = 32'h0000_0037;
        tick(1);
        rs_data = 32'h0000_0008;
        tick(1);
        idle();
        syscall = 1; instr = {26'd0, FN_SYSCALL}; v0 = 32'd1;
        tick(1);
        v0 = 32'd10;
        tick(1);
        repeat (10) begin
            rand_in();
            go = 0;
            tick(1);
        end
        idle();
        go = 1;
        tick(1);
        go = 0;
        tick(1);
        syscall = 1; v0 = 32'd10;
        tick(1);
        idle();
        tick(1);
        go = 1; rst = 1;
        tick(1);
        rst = 0;
        syscall = 1; v0 = 32'd10;
        tick(1);
        idle();
        go = 1;
        tick(1);
        syscall = 1; v0 = 32'd10;
        tick(1);
        syscall = 0;
        tick(1);
        idle();
        bne = 1; jr = 1; equal = 0; rs_data = 32'h0000_0100; instr = {OP_BNE, 10'd0, 16'h0004};
        tick(1);
        idle();
        j = 1; instr = {OP_J, 26'h3FF_FFFF};
        tick(1);
        idle();
        bne = 1; equal = 0; instr = {OP_BNE, 10'd0, 16'h8000};
        tick(1);
        idle();
        repeat (400) begin
            rand_in();
            rst = $urandom_range(0, 49) == 0;
            tick(1);
        end
        idle();
        rst = 1;
        tick(1);
        rst = 0;
        jr = 1;
        for (int i = 0; i < 65540; i++) begin
            rs_data = $urandom;
            tick(i == 65534 || i == 65535 || i == 65539);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
